// File: rtl/counter.sv
// rtl/counter.sv - loadable up/down counter with asynchronous active-low reset
//
// Purpose:
//   WIDTH-bit synchronous counter. On each rising clk edge it either loads D
//   or steps by +1/-1, wrapping modulo 2^WIDTH. Priority is reset, then load,
//   then count.
//
// Ports:
//   D       in   WIDTH  parallel load value, sampled when load=1
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous reset, active-low (0 clears Count)
//   load    in   1      synchronous load enable, active-high
//   updown  in   1      direction: 1 counts up, 0 counts down (ignored on load)
//   Count   out  WIDTH  current count, driven straight from the state register

module counter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] D,
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             updown,
  output logic [WIDTH-1:0] Count
);

  logic [WIDTH-1:0] count_next;

  // Load wins over counting. Carry/borrow out of the top bit is discarded,
  // which gives the silent modulo wrap in both directions.
  always_comb begin
    count_next = Count;
    if (load) begin
      count_next = D;
    end else if (updown) begin
      count_next = Count + WIDTH'(1);
    end else begin
      count_next = Count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Count <= '0;
    end else begin
      Count <= count_next;
    end
  end

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - directed self-checking bench for counter

module tb_counter;

  logic [3:0] D;
  logic       clk;
  logic       rst;
  logic       load;
  logic       updown;
  logic [3:0] Count;

  int passed = 0;
  int total  = 0;

  counter #(.WIDTH(4)) dut (
    .D      (D),
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .updown (updown),
    .Count  (Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] exp);
    total++;
    assert (Count === exp) passed++;
    else $error("FAIL %s: Count=%0d expected %0d", tag, Count, exp);
  endtask

  // Advance one rising edge and settle 1 ns past it before checking.
  task automatic step(input string tag, input logic [3:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    D = 4'd0; load = 1'b0; updown = 1'b1; rst = 1'b0;
    #1;
    chk("reset_initial", 4'd0);
    step("reset_hold_edge1", 4'd0);
    step("reset_hold_edge2", 4'd0);

    // Release between edges, count up from 0.
    rst = 1'b1;
    step("up_from_reset_1", 4'd1);
    step("up_from_reset_2", 4'd2);
    step("up_from_reset_3", 4'd3);

    // Load 9 then count up.
    load = 1'b1; D = 4'b1001;
    step("load_9", 4'd9);
    load = 1'b0;
    step("up_after_load_10", 4'd10);
    step("up_after_load_11", 4'd11);
    step("up_after_load_12", 4'd12);

    // Up wrap through 15 -> 0.
    load = 1'b1; D = 4'd14;
    step("load_14", 4'd14);
    load = 1'b0;
    step("up_wrap_15", 4'd15);
    step("up_wrap_0", 4'd0);
    step("up_wrap_1", 4'd1);

    // Down count with wrap 0 -> 15.
    load = 1'b1; D = 4'd2;
    step("load_2", 4'd2);
    load = 1'b0; updown = 1'b0;
    step("down_1", 4'd1);
    step("down_0", 4'd0);
    step("down_wrap_15", 4'd15);
    step("down_14", 4'd14);

    // Load beats a down count on the same edge.
    load = 1'b1; D = 4'd5; updown = 1'b0;
    step("load_beats_down", 4'd5);
    // Held load follows D.
    D = 4'd7;
    step("load_held_follow_7", 4'd7);
    load = 1'b0; updown = 1'b1;
    step("up_after_held_load", 4'd8);

    // Asynchronous clear between edges from a count of 7.
    load = 1'b1; D = 4'd7;
    step("load_7", 4'd7);
    load = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_clear_from_7", 4'd0);
    #1;
    rst = 1'b1;
    step("resume_after_clear", 4'd1);

    // Mid-run reset: 10 ns pulse spanning an edge, counting up from 5.
    load = 1'b1; D = 4'd5;
    step("load_5", 4'd5);
    load = 1'b0; updown = 1'b1;
    rst = 1'b0;
    #1;
    chk("midrun_clear_immediate", 4'd0);
    #9;
    chk("midrun_held_across_edge", 4'd0);
    rst = 1'b1;
    step("midrun_first_after_release", 4'd1);
    step("midrun_second_after_release", 4'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
